// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
package hazard_pkg;

    localparam int HAZ_REG_ADDR_W = 5;
    localparam int HAZ_CNT_W      = 32;

    typedef enum logic {
        RUN     = 1'b0,
        DISCARD = 1'b1
    } hazard_state_e;

    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic if_id_flush;
        logic id_ex_stall;
        logic id_ex_flush;
        logic ex_mem_stall;
        logic mem_wb_stall;
    } pipe_ctrl_t;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Free-running event counter; clear wins over a same-cycle increment.
module hazard_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             ACLK,
    input  logic             ARESETn,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, redirects,
// fetch and data-memory waits, plus hazard performance counters.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = HAZ_REG_ADDR_W,
    parameter int CNT_W      = HAZ_CNT_W
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic                  ex_mem_read,
    input  logic                  ex_redirect,
    input  logic                  im_busy,
    input  logic                  dm_busy,
    input  logic                  perf_clr,
    output logic                  pc_stall,
    output logic                  if_id_stall,
    output logic                  if_id_flush,
    output logic                  id_ex_stall,
    output logic                  id_ex_flush,
    output logic                  ex_mem_stall,
    output logic                  mem_wb_stall,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      redirect_cnt,
    output logic [CNT_W-1:0]      load_use_cnt
);

    hazard_state_e state_q;
    hazard_state_e state_d;
    pipe_ctrl_t    ctrl;
    logic          load_use;
    logic          redirect_inc;
    logic          load_use_inc;

    assign load_use = ex_mem_read && (ex_rd_addr != '0) &&
                      ((id_rs1_used && (id_rs1_addr == ex_rd_addr)) ||
                       (id_rs2_used && (id_rs2_addr == ex_rd_addr)));

    always_comb begin
        ctrl         = '0;
        state_d      = state_q;
        redirect_inc = 1'b0;
        load_use_inc = 1'b0;
        if (dm_busy) begin
            // Freeze everything; a pending redirect stays in EX and re-presents.
            ctrl.pc_stall     = 1'b1;
            ctrl.if_id_stall  = 1'b1;
            ctrl.id_ex_stall  = 1'b1;
            ctrl.ex_mem_stall = 1'b1;
            ctrl.mem_wb_stall = 1'b1;
        end else if (ex_redirect) begin
            ctrl.if_id_flush = 1'b1;
            ctrl.id_ex_flush = 1'b1;
            redirect_inc     = 1'b1;
            state_d          = im_busy ? DISCARD : RUN;
        end else if (state_q == DISCARD) begin
            // Wrong-path fetch still outstanding; kill its word when it lands.
            ctrl.if_id_flush = 1'b1;
            ctrl.pc_stall    = im_busy;
            if (!im_busy) begin
                state_d = RUN;
            end
        end else if (load_use) begin
            ctrl.pc_stall    = 1'b1;
            ctrl.if_id_stall = 1'b1;
            ctrl.id_ex_flush = 1'b1;
            load_use_inc     = 1'b1;
        end else if (im_busy) begin
            ctrl.pc_stall    = 1'b1;
            ctrl.if_id_flush = 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign pc_stall     = ctrl.pc_stall;
    assign if_id_stall  = ctrl.if_id_stall;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_stall  = ctrl.id_ex_stall;
    assign id_ex_flush  = ctrl.id_ex_flush;
    assign ex_mem_stall = ctrl.ex_mem_stall;
    assign mem_wb_stall = ctrl.mem_wb_stall;

    hazard_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .inc     (ctrl.pc_stall),
        .clr     (perf_clr),
        .count   (stall_cycles)
    );

    hazard_perf_cnt #(.CNT_W(CNT_W)) u_redirect_cnt (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .inc     (redirect_inc),
        .clr     (perf_clr),
        .count   (redirect_cnt)
    );

    hazard_perf_cnt #(.CNT_W(CNT_W)) u_load_use_cnt (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .inc     (load_use_inc),
        .clr     (perf_clr),
        .count   (load_use_cnt)
    );

endmodule
